// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle processor control FSM (IF -> ID -> EXE -> [MEM] -> [WB] -> IF).
// Optional feature macro: MC_PERF_CNT_EN adds a 32-bit retired-instruction counter
// on instret. When the macro is undefined, instret is tied to 0 and no counter exists.
//
// Handshake/strobe semantics: every strobe is a one-cycle pulse decoded from the
// registered state and class flags, qualified by (!reset && !hold). hold freezes
// state and flags; reset wins over hold and abandons any instruction in flight.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        id_inst_valid,
  input  logic        id_is_load,
  input  logic        id_is_store,
  input  logic        id_wr_rd,
  output logic [2:0]  state,
  output logic        inst_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        dsram_we,
  output logic        retire,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q;
  logic   valid_q;
  logic   load_q;
  logic   store_q;
  logic   wr_rd_q;
  logic   active;

  // Strobes may only fire when neither reset nor hold is asserted.
  assign active = !reset && !hold;
  assign state  = state_q;

  // State register and instruction class flags captured in ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      valid_q <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      wr_rd_q <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        S_IF: state_q <= S_ID;
        S_ID: begin
          valid_q <= id_inst_valid;
          // A load that also claims to be a store is treated as a load.
          load_q  <= id_is_load;
          store_q <= id_is_store && !id_is_load;
          wr_rd_q <= id_wr_rd;
          state_q <= S_EXE;
        end
        S_EXE: begin
          if (!valid_q)                state_q <= S_IF;
          else if (load_q || store_q)  state_q <= S_MEM;
          else if (wr_rd_q)            state_q <= S_WB;
          else                         state_q <= S_IF;
        end
        S_MEM: begin
          if (load_q) state_q <= S_WB;
          else        state_q <= S_IF;
        end
        S_WB:    state_q <= S_IF;
        default: state_q <= S_IF;
      endcase
    end
  end

  // Strobe decode: each instruction raises pc_we exactly once, in its final state.
  always_comb begin
    inst_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    dsram_we = 1'b0;
    retire   = 1'b0;
    if (active) begin
      case (state_q)
        S_IF: inst_req = 1'b1;
        S_ID: ir_we    = 1'b1;
        S_EXE: begin
          if (!valid_q) begin
            pc_we = 1'b1;
          end else if (!load_q && !store_q && !wr_rd_q) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          if (!load_q && store_q) begin
            dsram_we = 1'b1;
            pc_we    = 1'b1;
            retire   = 1'b1;
          end
        end
        S_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] instret_q;

  // Retired-instruction counter; retire is already suppressed under hold.
  always_ff @(posedge clk) begin
    if (reset)       instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule
